// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
//
// Round-robin arbiter sharing one resource among 8 requesters. A requester
// holds req high for as long as it needs ownership and drops it to release.
// After every release (voluntary or forced) there is exactly one grant-free
// GAP cycle, and the round-robin pointer moves to the requester after the
// previous owner.
//
// Handshake: req[i] is a level request. grant[i] (and grant_idx == i,
// grant_valid == 1) is a registered level acknowledgement that stays high
// while req[i] stays high. Ownership ends on the edge that samples req[i]
// low, or on a forced release when the hold limit is reached.
//
// Optional feature (compile-time macro HOLD_TIMEOUT_EN):
//   defined   - a hold counter bounds each ownership to MAX_HOLD cycles.
//               A forced release pulses timeout for its single GAP cycle.
//   undefined - no counter is built, timeout is tied low and ownership is
//               unbounded.
//
// Parameters:
//   MAX_HOLD  maximum grant cycles per ownership (2..255), timeout build only
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   en           in   enables new grants; never revokes the current owner
//   req[7:0]     in   request vector, bit i = requester i
//   grant[7:0]   out  registered one-hot grant (or all zero)
//   grant_idx    out  registered binary index of owner, 0 when no owner
//   grant_valid  out  registered, high while any grant bit is high
//   timeout      out  registered one-cycle pulse on a forced release
//   dbg_state    out  current FSM state (0 IDLE, 1 GRANT, 2 GAP)
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Elaboration-time sanity check of the parameter pair.
    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_param
        $error("rr_arbiter8: illegal MAX_HOLD/CNT_W combination");
    end

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       timeout_q, timeout_d;

    // Owner chosen for the next cycle; only meaningful when state_d == GRANT.
    logic [2:0] owner_d;

    // Round-robin winner search.
    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;

`ifdef HOLD_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_limit;

    // hold_cnt_q counts completed GRANT cycles minus one, so the edge ending
    // the MAX_HOLD-th grant cycle sees hold_cnt_q == MAX_HOLD-1.
    assign hold_limit = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

    // -----------------------------------------------------------------------
    // Winner: first set req bit scanning ptr, ptr+1, ..., wrapping mod 8.
    // Scanning from the far end down lets the nearest candidate win last.
    // -----------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr_q + 3'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register (also holds pointer, registered outputs and counter).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= 3'd0;
            grant_q       <= 8'h00;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = grant_idx_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE, GAP: begin
                if (en && win_found) begin
                    state_d = GRANT;
                    owner_d = win_idx;
                end else begin
                    state_d = IDLE;
                    owner_d = 3'd0;
                end
            end

            GRANT: begin
                // Voluntary release wins over a simultaneous hold limit.
                if (!req[grant_idx_q]) begin
                    state_d = GAP;
                    ptr_d   = grant_idx_q + 3'd1;
                    owner_d = 3'd0;
                end
`ifdef HOLD_TIMEOUT_EN
                else if (hold_limit) begin
                    state_d   = GAP;
                    ptr_d     = grant_idx_q + 3'd1;
                    owner_d   = 3'd0;
                    timeout_d = 1'b1;
                end
`endif
            end

            default: begin
                state_d = IDLE;
                owner_d = 3'd0;
            end
        endcase
    end

`ifdef HOLD_TIMEOUT_EN
    // Counter restarts on every entry into GRANT and runs while GRANT holds.
    always_comb begin
        hold_cnt_d = '0;
        if (state_q == GRANT && state_d == GRANT) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Output logic: next values of the registered outputs, derived from the
    // next state so every output is a flop.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_d       = 8'h00;
        grant_idx_d   = 3'd0;
        grant_valid_d = 1'b0;
        if (state_d == GRANT) begin
            grant_d       = 8'h01 << owner_d;
            grant_idx_d   = owner_d;
            grant_valid_d = 1'b1;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  logic [1:0] dbg_state;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Packed expectation: {timeout, grant_valid, grant_idx, grant}
  logic [12:0] exp_q[$];
  int          tag_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          step_no = 0;

  function automatic logic [12:0] pack_out();
    return {timeout, grant_valid, grant_idx, grant};
  endfunction

  task automatic compare(input string name, input int tag, input logic [12:0] act,
                         input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got to=%b v=%b idx=%0d grant=%h, want to=%b v=%b idx=%0d grant=%h",
               name, tag, act[12], act[11], act[10:8], act[7:0],
               exp[12], exp[11], exp[10:8], exp[7:0]);
    end
  endtask

  // Monitor: one expectation per checked edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      compare("step", tag_q.pop_front(), pack_out(), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Drive inputs for one cycle and record the outputs expected after the edge.
  task automatic step(input logic [7:0] r, input logic e, input logic [7:0] g,
                      input logic [2:0] idx, input logic to);
    @(negedge clk);
    req = r;
    en  = e;
    step_no++;
    exp_q.push_back({to, (g != 8'h00), idx, g});
    tag_q.push_back(step_no);
    @(posedge clk);
  endtask

  // Pulse reset asynchronously between edges and check outputs clear at once.
  task automatic async_reset(input string name);
    #3;
    reset = 1'b1;
    req   = 8'h00;
    #1;
    compare(name, step_no, pack_out(), 13'h0000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    en    = 1'b0;
    req   = 8'h00;
    #1;
    compare("reset", 0, pack_out(), 13'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-grant: owner 3, then async reset, then ptr back at 0.
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0);
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0);
    async_reset("reset_mid_grant");
    step(8'h09, 1'b1, 8'h01, 3'd0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);   // release -> GAP, ptr=1
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);   // IDLE

    // Single requester 5: held four edges, then dropped -> GAP, ptr=6.
    for (int i = 0; i < 4; i++) step(8'h20, 1'b1, 8'h20, 3'd5, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);

    // Wrap and skip: ptr=6, req=05 -> 0 first, then 2.
    step(8'h05, 1'b1, 8'h01, 3'd0, 1'b0);
    step(8'h05, 1'b1, 8'h01, 3'd0, 1'b0);
    step(8'h04, 1'b1, 8'h00, 3'd0, 1'b0);   // owner 0 drops, ptr=1
    step(8'h04, 1'b1, 8'h04, 3'd2, 1'b0);

    // en gating: owner 2 keeps grant with en=0, nothing new until en=1.
    step(8'h16, 1'b0, 8'h04, 3'd2, 1'b0);
    step(8'h16, 1'b0, 8'h04, 3'd2, 1'b0);
    step(8'h12, 1'b0, 8'h00, 3'd0, 1'b0);   // release, ptr=3
    step(8'h12, 1'b0, 8'h00, 3'd0, 1'b0);
    step(8'h12, 1'b0, 8'h00, 3'd0, 1'b0);
    step(8'h12, 1'b1, 8'h10, 3'd4, 1'b0);   // scan from 3 finds 4
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);

    // Rotation from ptr=0 with all requesting: owners 0..7 then 0 again.
    async_reset("reset_before_rotation");
    for (int k = 0; k < 9; k++) begin
      logic [2:0] w;
      logic [7:0] oh;
      w  = 3'(k);
      oh = 8'h01 << w;
      step(8'hFF, 1'b1, oh, w, 1'b0);
      step(8'hFF, 1'b1, oh, w, 1'b0);
      step(8'hFF & ~oh, 1'b1, 8'h00, 3'd0, 1'b0);
    end

    // Hold limit: ptr=1, requester 1 holds req continuously.
`ifdef HOLD_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD; i++) step(8'h02, 1'b1, 8'h02, 3'd1, 1'b0);
    step(8'h02, 1'b1, 8'h00, 3'd0, 1'b1);   // forced release
    step(8'h02, 1'b1, 8'h02, 3'd1, 1'b0);
    step(8'h02, 1'b1, 8'h02, 3'd1, 1'b0);
`else
    for (int i = 0; i < MAX_HOLD + 3; i++) step(8'h02, 1'b1, 8'h02, 3'd1, 1'b0);
`endif
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);

    // Drain: every pushed expectation must have been checked.
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
Round-robin arbiter that shares one resource among 8 requesters. It emits a one-hot grant vector and the matching 3-bit index, so downstream logic can use either form. Sits in front of the shared resource. Requesters hold req high for as long as they need ownership and drop it to release.

Parameters:
MAX_HOLD, 16, maximum cycles one owner may hold the grant; used only when HOLD_TIMEOUT_EN is defined; legal range 2..255.
CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  arbitration enable; 0 blocks new grants but does not affect the current owner
req  input  8  request vector, bit i = requester i
grant  output  8  one-hot grant, registered
grant_idx  output  3  binary index of the owner, registered; 0 when grant_valid=0
grant_valid  output  1  high while any grant bit is high
timeout  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-grant):
  - grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0.
  - Round-robin pointer ptr=0, state=IDLE, hold counter=0.
- States: IDLE, GRANT, GAP. All outputs are registered.
- Arbitration (in IDLE or GAP, when en=1 and req!=0):
  - Winner w = first set bit scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - Next edge: state=GRANT, grant_idx=w, grant=(8'h01<<w), grant_valid=1.
  - Latency: req sampled at edge N gives grant visible after edge N.
- IDLE or GAP with en=0 or req==0: next state=IDLE, all grant outputs 0.
- GRANT:
  - While req[grant_idx]=1: hold the grant. Other req bits are ignored.
  - When req[grant_idx]=0 is sampled: at that edge grant=0, grant_valid=0, grant_idx=0, ptr=(owner+1) mod 8 (7 wraps to 0), state=GAP.
- GAP: exactly one grant-free cycle (all outputs 0), then arbitrates as above. Back-to-back owners are therefore separated by exactly 1 idle cycle.
- en deasserted during GRANT: the owner keeps the grant until it releases; no new grant is issued until en=1.
- Invariants:
  - grant is all-zero or exactly one-hot.
  - grant == one-hot decode of grant_idx whenever grant_valid=1.
  - grant_valid == |grant.
- Fairness: any requester that holds req continuously is granted within 7 other ownership periods.
- X/undefined req bits are not permitted; behaviour under X is unspecified.

Optional Feature:
HOLD_TIMEOUT_EN
- Defined:
  - The hold counter resets to 0 on entry to GRANT and increments each GRANT cycle.
  - When the owner has held grant_valid for MAX_HOLD consecutive cycles and req[owner] is still 1, the grant is forced low at the next edge. The forced release has the same GAP transition and ptr advance as a voluntary release.
  - timeout pulses high for exactly that one GAP cycle.
  - A voluntary release on the same edge as the limit takes priority: timeout=0.
- Undefined: no counter is built, timeout is tied to 0, and ownership is unbounded.

Test Plan:
- Reset mid-grant: owner 3 granted, assert reset asynchronously between edges -> grant=00, grant_idx=0, grant_valid=0 immediately; after reset, req=8'h09 -> grant=8'h01 (ptr back at 0).
- Single requester: req=8'h20 from edge 1, dropped at edge 5 -> grant=8'h20, grant_idx=5 after edges 1-4; grant=0 after edge 5 (GAP); ptr=6.
- Round-robin rotation: req=8'hFF held constant, each owner drops req for one cycle after 2 grant cycles -> owners 0,1,2,...,7,0 in order, each separated by one grant-free cycle.
- Wrap and skip: ptr=6, req=8'h05 -> grant=8'h01 (idx 0), then after release grant=8'h04 (idx 2).
- en gating: owner 2 holding, en=0, req=8'h12 -> grant stays 8'h04 until req[2] drops; then grant=0 and stays 0 while en=0; en=1 -> grant=8'h10.
- Timeout (HOLD_TIMEOUT_EN, MAX_HOLD=4): req=8'h02 held high -> grant=8'h02 for exactly 4 cycles, then grant=0 with timeout=1 for 1 cycle, then grant=8'h02 again; without the macro, grant stays 8'h02 and timeout stays 0.
